mips_mc_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS core (MIPS_new datapath). Sequences every instruction through a fixed 5-cycle machine cycle (FETCH, DECODE, EXECUTE, MEMWB, DONE) and drives all datapath mux selects, write enables and ALU operation codes. It decodes opcode/funct from the datapath IR and exports its state on count_state for bench alignment.

---
 rtl/mips_mc_ctrl_if.sv | 44 ++++
 rtl/mips_mc_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multicycle MIPS datapath and its main FSM.
// slave is the controller side, master is the datapath side.
interface mips_mc_ctrl_if #(
  parameter int OP_WIDTH    = 6,
  parameter int FUNCT_WIDTH = 6,
  parameter int ALUC_WIDTH  = 4
);
  logic                   enable;
  logic [OP_WIDTH-1:0]    opcode;
  logic [FUNCT_WIDTH-1:0] funct;
  logic                   zero;
  logic                   pc_write;
  logic [1:0]             pc_src;
  logic                   iord;
  logic                   mem_write;
  logic                   ir_write;
  logic                   reg_dst;
  logic                   mem_to_reg;
  logic                   reg_write;
  logic                   alu_src_a;
  logic [2:0]             alu_src_b;
  logic [ALUC_WIDTH-1:0]  alu_ctrl;
  logic                   instr_done;
  logic                   illegal_op;
  logic [2:0]             count_state;

  modport master (
    output enable, opcode, funct, zero,
    input  pc_write, pc_src, iord, mem_write,
    input  ir_write, reg_dst, mem_to_reg,
    input  reg_write, alu_src_a, alu_src_b,
    input  alu_ctrl, instr_done, illegal_op,
    input  count_state
  );

  modport slave (
    input  enable, opcode, funct, zero,
    output pc_write, pc_src, iord, mem_write,
    output ir_write, reg_dst, mem_to_reg,
    output reg_write, alu_src_a, alu_src_b,
    output alu_ctrl, instr_done, illegal_op,
    output count_state
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Main control FSM of the multicycle MIPS core: fixed 5-cycle sequence,
// Moore-decoded datapath controls from state, opcode and funct.
module mips_mc_ctrl #(
  parameter int OP_WIDTH    = 6,
  parameter int FUNCT_WIDTH = 6,
  parameter int ALUC_WIDTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  mips_mc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEMWB   = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_J    = OP_WIDTH'(6'b000010);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_BNE  = OP_WIDTH'(6'b000101);
  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_ANDI = OP_WIDTH'(6'b001100);
  localparam logic [OP_WIDTH-1:0] OP_ORI  = OP_WIDTH'(6'b001101);
  localparam logic [OP_WIDTH-1:0] OP_LUI  = OP_WIDTH'(6'b001111);
  localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);

  localparam logic [FUNCT_WIDTH-1:0] FN_SLL = FUNCT_WIDTH'(6'b000000);
  localparam logic [FUNCT_WIDTH-1:0] FN_ADD = FUNCT_WIDTH'(6'b100000);
  localparam logic [FUNCT_WIDTH-1:0] FN_SUB = FUNCT_WIDTH'(6'b100010);
  localparam logic [FUNCT_WIDTH-1:0] FN_AND = FUNCT_WIDTH'(6'b100100);
  localparam logic [FUNCT_WIDTH-1:0] FN_OR  = FUNCT_WIDTH'(6'b100101);
  localparam logic [FUNCT_WIDTH-1:0] FN_SLT = FUNCT_WIDTH'(6'b101010);

  localparam logic [ALUC_WIDTH-1:0] ALU_AND = ALUC_WIDTH'(4'b0000);
  localparam logic [ALUC_WIDTH-1:0] ALU_OR  = ALUC_WIDTH'(4'b0001);
  localparam logic [ALUC_WIDTH-1:0] ALU_ADD = ALUC_WIDTH'(4'b0010);
  localparam logic [ALUC_WIDTH-1:0] ALU_SUB = ALUC_WIDTH'(4'b0110);
  localparam logic [ALUC_WIDTH-1:0] ALU_SLT = ALUC_WIDTH'(4'b0111);
  localparam logic [ALUC_WIDTH-1:0] ALU_SLL = ALUC_WIDTH'(4'b1000);
  localparam logic [ALUC_WIDTH-1:0] ALU_LUI = ALUC_WIDTH'(4'b1001);

  state_t state;
  logic   illegal;

  logic is_r, is_j, is_beq, is_bne;
  logic is_addi, is_andi, is_ori, is_lui;
  logic is_lw, is_sw, is_br, is_wimm;
  logic fn_ok, legal;
  logic [ALUC_WIDTH-1:0] r_alu;

  assign is_r    = bus.opcode == OP_R;
  assign is_j    = bus.opcode == OP_J;
  assign is_beq  = bus.opcode == OP_BEQ;
  assign is_bne  = bus.opcode == OP_BNE;
  assign is_addi = bus.opcode == OP_ADDI;
  assign is_andi = bus.opcode == OP_ANDI;
  assign is_ori  = bus.opcode == OP_ORI;
  assign is_lui  = bus.opcode == OP_LUI;
  assign is_lw   = bus.opcode == OP_LW;
  assign is_sw   = bus.opcode == OP_SW;
  assign is_br   = is_beq | is_bne;
  assign is_wimm = is_addi | is_andi
                 | is_ori | is_lui;

  always_comb begin
    r_alu = ALU_AND;
    fn_ok = 1'b1;
    unique case (bus.funct)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OR:   r_alu = ALU_OR;
      FN_SLT:  r_alu = ALU_SLT;
      FN_SLL:  r_alu = ALU_SLL;
      default: fn_ok = 1'b0;
    endcase
  end

  assign legal = (is_r & fn_ok) | is_j | is_br
               | is_wimm | is_lw | is_sw;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      illegal <= 1'b0;
    end else begin
      if (state == DECODE && !legal)
        illegal <= 1'b1;
      unique case (state)
        IDLE:    state <= bus.enable ? FETCH : IDLE;
        FETCH:   state <= DECODE;
        DECODE:  state <= EXECUTE;
        EXECUTE: state <= MEMWB;
        MEMWB:   state <= DONE;
        DONE:    state <= bus.enable ? FETCH : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic       pw, io, mw, irw;
  logic       rd, m2r, rw, sa, dn;
  logic [1:0] ps;
  logic [2:0] sb;
  logic [ALUC_WIDTH-1:0] alu;

  always_comb begin
    pw  = 1'b0;
    ps  = 2'b00;
    io  = 1'b0;
    mw  = 1'b0;
    irw = 1'b0;
    rd  = 1'b0;
    m2r = 1'b0;
    rw  = 1'b0;
    sa  = 1'b0;
    sb  = 3'b000;
    alu = ALU_AND;
    dn  = 1'b0;
    unique case (state)
      FETCH: begin
        irw = 1'b1;
        pw  = 1'b1;
        sb  = 3'b001;
        alu = ALU_ADD;
      end
      DECODE: begin
        sb  = 3'b011;
        alu = ALU_ADD;
      end
      EXECUTE: begin
        unique case (1'b1)
          is_r: begin
            sa  = 1'b1;
            alu = r_alu;
          end
          is_addi, is_lw, is_sw: begin
            sa  = 1'b1;
            sb  = 3'b010;
            alu = ALU_ADD;
          end
          is_andi: begin
            sa  = 1'b1;
            sb  = 3'b100;
          end
          is_ori: begin
            sa  = 1'b1;
            sb  = 3'b100;
            alu = ALU_OR;
          end
          is_lui: begin
            sb  = 3'b100;
            alu = ALU_LUI;
          end
          is_br: begin
            sa  = 1'b1;
            alu = ALU_SUB;
            ps  = 2'b01;
            pw  = bus.zero ^ is_bne;
          end
          is_j: begin
            pw  = 1'b1;
            ps  = 2'b10;
          end
          default: ;
        endcase
      end
      MEMWB: begin
        unique case (1'b1)
          is_r: begin
            rw = 1'b1;
            rd = 1'b1;
          end
          is_wimm: rw = 1'b1;
          is_sw: begin
            io = 1'b1;
            mw = 1'b1;
          end
          is_lw:   io = 1'b1;
          default: ;
        endcase
      end
      DONE: begin
        dn = 1'b1;
        if (is_lw) begin
          io  = 1'b1;
          rw  = 1'b1;
          m2r = 1'b1;
        end
      end
      default: ;
    endcase
    // an unsupported instruction still walks the sequence but commits nothing
    if (!legal && state inside {EXECUTE, MEMWB, DONE}) begin
      pw = 1'b0;
      mw = 1'b0;
      rw = 1'b0;
    end
  end

  assign bus.pc_write    = reset & pw;
  assign bus.pc_src      = {2{reset}} & ps;
  assign bus.iord        = reset & io;
  assign bus.mem_write   = reset & mw;
  assign bus.ir_write    = reset & irw;
  assign bus.reg_dst     = reset & rd;
  assign bus.mem_to_reg  = reset & m2r;
  assign bus.reg_write   = reset & rw;
  assign bus.alu_src_a   = reset & sa;
  assign bus.alu_src_b   = {3{reset}} & sb;
  assign bus.alu_ctrl    = {ALUC_WIDTH{reset}} & alu;
  assign bus.instr_done  = reset & dn;
  assign bus.illegal_op  = illegal;
  assign bus.count_state = state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: stimulus queues hand-computed
// per-cycle control vectors, a negedge monitor pops and compares.
module tb_mips_mc_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mips_mc_ctrl_if bus ();

  mips_mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [17:0] ctl;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;
  logic ill_exp;

  logic [17:0] Z, DN, F_V, D_V;
  logic [17:0] EX_ADD, WB_I, WB_R;

  function automatic logic [17:0] c(
    input logic pw, input logic [1:0] ps,
    input logic io, input logic mw,
    input logic irw, input logic rd,
    input logic m2r, input logic rw,
    input logic a, input logic [2:0] b,
    input logic [3:0] al, input logic dn
  );
    return {pw, ps, io, mw, irw, rd, m2r,
            rw, a, b, al, dn};
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [17:0] got;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {bus.pc_write, bus.pc_src,
             bus.iord, bus.mem_write,
             bus.ir_write, bus.reg_dst,
             bus.mem_to_reg, bus.reg_write,
             bus.alu_src_a, bus.alu_src_b,
             bus.alu_ctrl, bus.instr_done};
      total++;
      if (bus.count_state === e.st &&
          got === e.ctl &&
          bus.illegal_op === e.ill)
        passed++;
      else
        $display("FAIL %s: st %0d ctl %h ill %b, want st %0d ctl %h ill %b",
                 e.name, bus.count_state, got,
                 bus.illegal_op, e.st, e.ctl, e.ill);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [2:0] st,
                     input logic [17:0] v);
    exp_t e;
    e.name = nm;
    e.st   = st;
    e.ctl  = v;
    e.ill  = ill_exp;
    q.push_back(e);
  endtask

  task automatic run(input string nm,
                     input logic [31:0] ir,
                     input logic z, input logic en_mid,
                     input logic bad,
                     input logic [17:0] ex,
                     input logic [17:0] mw,
                     input logic [17:0] dn);
    tick();
    bus.opcode = ir[31:26];
    bus.funct  = ir[5:0];
    bus.zero   = 1'b0;
    chk({nm, ".F"}, 3'd1, F_V);
    tick();
    chk({nm, ".D"}, 3'd2, D_V);
    if (bad) ill_exp = 1'b1;
    tick();
    bus.zero   = z;
    bus.enable = en_mid;
    chk({nm, ".E"}, 3'd3, ex);
    tick();
    chk({nm, ".M"}, 3'd4, mw);
    tick();
    chk({nm, ".W"}, 3'd5, dn);
  endtask

  initial begin
    Z      = '0;
    DN     = 18'd1;
    F_V    = c(1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 3'b001, 4'b0010, 0);
    D_V    = c(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3'b011, 4'b0010, 0);
    EX_ADD = c(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 3'b010, 4'b0010, 0);
    WB_I   = c(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 3'b000, 4'b0000, 0);
    WB_R   = c(0, 2'b00, 0, 0, 0, 1, 0, 1, 0, 3'b000, 4'b0000, 0);
    ill_exp    = 1'b0;
    reset      = 1'b0;
    bus.enable = 1'b0;
    bus.opcode = '0;
    bus.funct  = '0;
    bus.zero   = 1'b0;

    tick();
    chk("reset", 3'd0, Z);
    reset      = 1'b1;
    bus.enable = 1'b1;

    run("addi", 32'h21080003, 0, 1, 0,
        EX_ADD, WB_I, DN);
    run("beq.z1", 32'h11090002, 1, 1, 0,
        c(1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 3'b000, 4'b0110, 0),
        Z, DN);
    run("beq.z0", 32'h11090002, 0, 1, 0,
        c(0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 3'b000, 4'b0110, 0),
        Z, DN);
    run("bne.z1", 32'h15090002, 1, 1, 0,
        c(0, 2'b01, 0, 0, 0, 0, 0, 0, 1, 3'b000, 4'b0110, 0),
        Z, DN);
    run("bne.z0", 32'h15090002, 0, 1, 0,
        c(1, 2'b01, 0, 0, 0, 0, 0, 0, 1, 3'b000, 4'b0110, 0),
        Z, DN);
    run("sw", 32'had910000, 0, 1, 0, EX_ADD,
        c(0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 0),
        DN);
    run("lw", 32'h8d940000, 0, 1, 0, EX_ADD,
        c(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 0),
        c(0, 2'b00, 1, 0, 0, 0, 1, 1, 0, 3'b000, 4'b0000, 1));
    run("sll", 32'h00118880, 0, 1, 0,
        c(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 3'b000, 4'b1000, 0),
        WB_R, DN);
    run("or", 32'h022a9025, 0, 1, 0,
        c(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 3'b000, 4'b0001, 0),
        WB_R, DN);
    run("lui", 32'h3c01abcd, 0, 1, 0,
        c(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3'b100, 4'b1001, 0),
        WB_I, DN);
    run("j", 32'h08000010, 0, 1, 0,
        c(1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 0),
        Z, DN);
    run("ill", 32'hfc000000, 0, 1, 1, Z, Z, DN);
    run("addi2", 32'h21080003, 0, 0, 0,
        EX_ADD, WB_I, DN);
    tick();
    chk("idle", 3'd0, Z);
    bus.enable = 1'b1;

    tick();
    bus.opcode = 6'b100011;
    bus.funct  = 6'b000000;
    chk("lwr.F", 3'd1, F_V);
    tick();
    chk("lwr.D", 3'd2, D_V);
    tick();
    chk("lwr.E", 3'd3, EX_ADD);
    tick();
    reset = 1'b0;
    chk("lwr.M", 3'd4, Z);
    tick();
    ill_exp = 1'b0;
    chk("rst.mid", 3'd0, Z);
    tick();
    chk("rst.en", 3'd0, Z);
    reset = 1'b1;

    run("addi3", 32'h21080003, 0, 0, 0,
        EX_ADD, WB_I, DN);
    tick();
    chk("idle2", 3'd0, Z);

    tick();
    tick();
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d left, want 0",
               q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
